// File: rtl/hdr_stream_ctrl.sv
// Pairs short/long exposure streams, issues operands to a fixed-latency HDR datapath and
// buffers its results in a credit-guarded FIFO. Define HDR_STREAM_CTRL_STAT_EN for statistics.
module hdr_stream_ctrl #(
    parameter int DATA_WIDTH = 10,
    parameter int HDR_LAT    = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s0_valid,
    output logic                  s0_ready,
    input  logic                  s0_sof,
    input  logic                  s0_eol,
    input  logic [DATA_WIDTH-1:0] s0_data,
    input  logic                  s1_valid,
    output logic                  s1_ready,
    input  logic                  s1_sof,
    input  logic                  s1_eol,
    input  logic [DATA_WIDTH-1:0] s1_data,
    output logic [DATA_WIDTH-1:0] hdr_data0,
    output logic [DATA_WIDTH-1:0] hdr_data1,
    input  logic [DATA_WIDTH+1:0] hdr_result,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_sof,
    output logic                  m_eol,
    output logic [DATA_WIDTH+1:0] m_data,
    output logic                  err_sync,
    output logic [15:0]           frame_cnt,
    output logic [15:0]           drop_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_WIDTH + 4;
    localparam logic [AW:0] PTR_ONE    = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] CREDIT_MAX = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        RESYNC = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_errSync;
    logic [DATA_WIDTH-1:0] r_data0;
    logic [DATA_WIDTH-1:0] r_data1;
    logic [HDR_LAT-1:0]    r_pipeValid;
    logic [HDR_LAT-1:0]    r_pipeSof;
    logic [HDR_LAT-1:0]    r_pipeEol;
    logic [AW:0]           r_credit;
    logic [AW:0]           r_wrPtr;
    logic [AW:0]           r_rdPtr;
    logic [EW-1:0]         r_mem [FIFO_DEPTH];

    logic          w_creditOk;
    logic          w_issue;
    logic          w_mismatch;
    logic          w_token;
    logic          w_drop0;
    logic          w_drop1;
    logic          w_bothSof;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic [EW-1:0] w_head;

    // Credit covers both in-flight tokens and FIFO entries, so a write always finds room.
    assign w_creditOk = r_credit < CREDIT_MAX;
    assign w_issue    = (r_state == RUN) && s0_valid && s1_valid && w_creditOk;
    assign w_mismatch = (s0_sof != s1_sof) || (s0_eol != s1_eol);
    assign w_token    = w_issue && !w_mismatch;
    assign w_drop0    = (r_state != RUN) && s0_valid && !s0_sof;
    assign w_drop1    = (r_state != RUN) && s1_valid && !s1_sof;
    assign w_bothSof  = s0_valid && s0_sof && s1_valid && s1_sof;
    assign w_push     = r_pipeValid[HDR_LAT-1];
    assign w_empty    = (r_wrPtr == r_rdPtr);
    assign w_pop      = !w_empty && m_ready;
    assign w_head     = r_mem[r_rdPtr[AW-1:0]];

    always_comb begin
        s0_ready = 1'b0;
        s1_ready = 1'b0;
        if (!rst) begin
            if (r_state == RUN) begin
                s0_ready = w_issue;
                s1_ready = w_issue;
            end else begin
                s0_ready = w_drop0;
                s1_ready = w_drop1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_errSync <= 1'b0;
            r_data0   <= '0;
            r_data1   <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_issue && w_mismatch) begin
                        r_errSync <= 1'b1;
                        r_state   <= RESYNC;
                    end
                end
                default: begin
                    if (w_bothSof) begin
                        r_state <= RUN;
                    end
                end
            endcase
            if (w_token) begin
                r_data0 <= s0_data;
                r_data1 <= s1_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipeValid <= '0;
            r_pipeSof   <= '0;
            r_pipeEol   <= '0;
        end else begin
            r_pipeValid <= {r_pipeValid[HDR_LAT-2:0], w_token};
            r_pipeSof   <= {r_pipeSof[HDR_LAT-2:0], s0_sof};
            r_pipeEol   <= {r_pipeEol[HDR_LAT-2:0], s0_eol};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr  <= '0;
            r_rdPtr  <= '0;
            r_credit <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
            case ({w_token, w_pop})
                2'b10:   r_credit <= r_credit + PTR_ONE;
                2'b01:   r_credit <= r_credit - PTR_ONE;
                default: r_credit <= r_credit;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr[AW-1:0]] <= {hdr_result, r_pipeSof[HDR_LAT-1], r_pipeEol[HDR_LAT-1]};
        end
    end

    assign hdr_data0 = r_data0;
    assign hdr_data1 = r_data1;
    assign err_sync  = r_errSync;
    assign m_valid   = !w_empty;
    assign m_sof     = !w_empty && w_head[1];
    assign m_eol     = !w_empty && w_head[0];
    assign m_data    = w_empty ? '0 : w_head[EW-1:2];

`ifdef HDR_STREAM_CTRL_STAT_EN
    logic [15:0] r_frameCnt;
    logic [15:0] r_dropCnt;
    logic [1:0]  w_dropInc;
    logic [16:0] w_dropSum;

    // A mismatched pair discards one beat from each stream.
    assign w_dropInc = (w_issue && w_mismatch) ? 2'd2 : ({1'b0, w_drop0} + {1'b0, w_drop1});
    assign w_dropSum = {1'b0, r_dropCnt} + {15'd0, w_dropInc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frameCnt <= '0;
            r_dropCnt  <= '0;
        end else begin
            if (w_pop && w_head[0]) begin
                r_frameCnt <= r_frameCnt + 16'd1;
            end
            r_dropCnt <= w_dropSum[16] ? 16'hFFFF : w_dropSum[15:0];
        end
    end

    assign frame_cnt = r_frameCnt;
    assign drop_cnt  = r_dropCnt;
`else
    assign frame_cnt = '0;
    assign drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_hdr_stream_ctrl.sv
// Self-checking bench for hdr_stream_ctrl: table-driven lines plus hand-written corner cases,
// with a scoreboard queue of expected result beats and a sum-of-operands datapath model.
module tb_hdr_stream_ctrl;
    localparam int DW    = 10;
    localparam int LAT   = 8;
    localparam int DEPTH = 16;
    localparam int RW    = DW + 2;

    typedef struct {
        logic [DW-1:0] data;
        logic          sof;
        logic          eol;
    } beat_t;

    typedef struct {
        logic [RW-1:0] data;
        logic          sof;
        logic          eol;
    } res_t;

    typedef struct {
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic          sof;
        logic          eol;
        logic [RW-1:0] expData;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          s0_valid, s0_ready, s0_sof, s0_eol;
    logic [DW-1:0] s0_data;
    logic          s1_valid, s1_ready, s1_sof, s1_eol;
    logic [DW-1:0] s1_data;
    logic [DW-1:0] hdr_data0, hdr_data1;
    logic [RW-1:0] hdr_result;
    logic          m_valid, m_ready, m_sof, m_eol;
    logic [RW-1:0] m_data;
    logic          err_sync;
    logic [15:0]   frame_cnt, drop_cnt;
    logic [RW-1:0] dpPipe [LAT-1];

    beat_t q0[$];
    beat_t q1[$];
    res_t  sb[$];

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int pairCnt = 0;
    int acc0Cnt = 0;
    int acc1Cnt = 0;
    int outCnt = 0;
    int firstPair = -1;
    int firstOut = -1;

    hdr_stream_ctrl #(.DATA_WIDTH(DW), .HDR_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_sof(s0_sof), .s0_eol(s0_eol), .s0_data(s0_data),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_sof(s1_sof), .s1_eol(s1_eol), .s1_data(s1_data),
        .hdr_data0(hdr_data0), .hdr_data1(hdr_data1), .hdr_result(hdr_result),
        .m_valid(m_valid), .m_ready(m_ready), .m_sof(m_sof), .m_eol(m_eol), .m_data(m_data),
        .err_sync(err_sync), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Datapath model: the sum of the operands is valid HDR_LAT cycles after the issue cycle.
    always @(posedge clk) begin
        dpPipe[0] <= RW'(hdr_data0) + RW'(hdr_data1);
        for (int k = 1; k < LAT - 1; k++) dpPipe[k] <= dpPipe[k-1];
    end
    assign hdr_result = dpPipe[LAT-2];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic pushBeat(input int stream, input logic [DW-1:0] d, input logic sof, input logic eol);
        beat_t b;
        b.data = d;
        b.sof  = sof;
        b.eol  = eol;
        if (stream == 0) q0.push_back(b);
        else q1.push_back(b);
    endtask

    task automatic expectRes(input logic [RW-1:0] d, input logic sof, input logic eol);
        res_t r;
        r.data = d;
        r.sof  = sof;
        r.eol  = eol;
        sb.push_back(r);
    endtask

    task automatic applyStimulus(input vec_t v);
        pushBeat(0, v.d0, v.sof, v.eol);
        pushBeat(1, v.d1, v.sof, v.eol);
        expectRes(v.expData, v.sof, v.eol);
    endtask

    task automatic presentHeads();
        if (q0.size() > 0) begin
            s0_valid = 1'b1; s0_data = q0[0].data; s0_sof = q0[0].sof; s0_eol = q0[0].eol;
        end else begin
            s0_valid = 1'b0; s0_sof = 1'b0; s0_eol = 1'b0;
        end
        if (q1.size() > 0) begin
            s1_valid = 1'b1; s1_data = q1[0].data; s1_sof = q1[0].sof; s1_eol = q1[0].eol;
        end else begin
            s1_valid = 1'b0; s1_sof = 1'b0; s1_eol = 1'b0;
        end
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while ((sb.size() != 0 || q0.size() != 0 || q1.size() != 0) && n < 600) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= 600) begin
            errors++;
            $display("[TB] FAIL %s_drain: got %0d results still pending, required 0", name, sb.size());
        end
        repeat (15) @(posedge clk);
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        q0.delete();
        q1.delete();
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Source driver: handshakes are judged at the negedge, queues advance just after the posedge.
    initial begin : driver
        logic a0, a1;
        s0_valid = 1'b0; s0_sof = 1'b0; s0_eol = 1'b0; s0_data = '0;
        s1_valid = 1'b0; s1_sof = 1'b0; s1_eol = 1'b0; s1_data = '0;
        forever begin
            @(negedge clk);
            a0 = s0_valid && s0_ready;
            a1 = s1_valid && s1_ready;
            if (a0) acc0Cnt++;
            if (a1) acc1Cnt++;
            if (a0 && a1) begin
                pairCnt++;
                if (firstPair < 0) firstPair = cycle;
            end
            @(posedge clk);
            #1;
            if (a0 && q0.size() > 0) void'(q0.pop_front());
            if (a1 && q1.size() > 0) void'(q1.pop_front());
            presentHeads();
        end
    end

    initial begin : monitor
        res_t e;
        forever begin
            @(negedge clk);
            if (m_valid && firstOut < 0) firstOut = cycle;
            if (m_valid && m_ready) begin
                outCnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output: got data=%0d sof=%0d eol=%0d, required no beat",
                             m_data, m_sof, m_eol);
                end else begin
                    e = sb.pop_front();
                    checkOutput("m_beat", 32'({m_data, m_sof, m_eol}), 32'({e.data, e.sof, e.eol}));
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        vec_t tbl[8];
        int   a0b, a1b, outBefore, n;

        rst = 1'b1;
        m_ready = 1'b1;
        pushBeat(0, 10'd9, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
        checkOutput("rst_s0_ready", 32'(s0_ready), 32'd0);
        checkOutput("rst_err_sync", 32'(err_sync), 32'd0);
        checkOutput("rst_hdr_data0", 32'(hdr_data0), 32'd0);
        checkOutput("rst_m_data", 32'(m_data), 32'd0);
        checkOutput("rst_m_sof", 32'(m_sof), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] aligned lines and latency");
        tbl[0] = '{10'd100,  10'd200,  1'b1, 1'b0, 12'd300};
        tbl[1] = '{10'd100,  10'd200,  1'b0, 1'b0, 12'd300};
        tbl[2] = '{10'd100,  10'd200,  1'b0, 1'b0, 12'd300};
        tbl[3] = '{10'd100,  10'd200,  1'b0, 1'b1, 12'd300};
        tbl[4] = '{10'd1023, 10'd1023, 1'b0, 1'b0, 12'd2046};
        tbl[5] = '{10'd0,    10'd0,    1'b0, 1'b1, 12'd0};
        tbl[6] = '{10'd5,    10'd7,    1'b1, 1'b0, 12'd12};
        tbl[7] = '{10'd512,  10'd511,  1'b0, 1'b1, 12'd1023};
        firstPair = -1;
        firstOut = -1;
        for (int i = 0; i < 8; i++) applyStimulus(tbl[i]);
        waitDrain("t1");
        checkOutput("t1_latency", 32'(firstOut - firstPair), 32'(LAT + 1));

        $display("[TB] backpressure with full credit");
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        pairCnt = 0;
        for (int i = 0; i < 24; i++) begin
            pushBeat(0, DW'(i), i == 0, i == 23);
            pushBeat(1, DW'(2 * i + 1), i == 0, i == 23);
            expectRes(RW'(3 * i + 1), i == 0, i == 23);
        end
        repeat (40) @(posedge clk);
        @(negedge clk);
        checkOutput("t2_issue_count", 32'(pairCnt), 32'(DEPTH));
        checkOutput("t2_m_valid", 32'(m_valid), 32'd1);
        checkOutput("t2_s0_ready", 32'(s0_ready), 32'd0);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        waitDrain("t2");

        $display("[TB] eol mismatch and resync");
        for (int i = 0; i < 6; i++) begin
            pushBeat(0, DW'(10 + i), i == 0, i == 3 || i == 5);
            pushBeat(1, DW'(20 + i), i == 0, i == 5);
            if (i < 3) expectRes(RW'(30 + 2 * i), i == 0, 1'b0);
        end
        pushBeat(0, 10'd50, 1'b1, 1'b0);
        pushBeat(1, 10'd60, 1'b1, 1'b0);
        expectRes(12'd110, 1'b1, 1'b0);
        pushBeat(0, 10'd1, 1'b0, 1'b1);
        pushBeat(1, 10'd2, 1'b0, 1'b1);
        expectRes(12'd3, 1'b0, 1'b1);
        waitDrain("t4");
        checkOutput("t4_err_sync", 32'(err_sync), 32'd1);

        $display("[TB] reset with tokens in flight");
        pairCnt = 0;
        for (int i = 0; i < 5; i++) begin
            pushBeat(0, 10'd3, i == 0, i == 4);
            pushBeat(1, 10'd4, i == 0, i == 4);
        end
        n = 0;
        do begin
            @(posedge clk);
            #3;
            n++;
        end while (pairCnt < 5 && n < 100);
        checkOutput("t6_issue_count", 32'(pairCnt), 32'd5);
        rst = 1'b1;
        outBefore = outCnt;
        @(negedge clk);
        checkOutput("t6_m_valid", 32'(m_valid), 32'd0);
        checkOutput("t6_s0_ready", 32'(s0_ready), 32'd0);
        checkOutput("t6_err_sync", 32'(err_sync), 32'd0);
        checkOutput("t6_hdr_data1", 32'(hdr_data1), 32'd0);
        q0.delete();
        q1.delete();
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        checkOutput("t6_no_stale", 32'(outCnt - outBefore), 32'd0);

        $display("[TB] leading non-sof beats on s1");
        a0b = acc0Cnt;
        a1b = acc1Cnt;
        for (int i = 0; i < 3; i++) pushBeat(1, 10'd77, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            pushBeat(0, DW'(i + 1), i == 0, i == 2);
            pushBeat(1, DW'(40 + i), i == 0, i == 2);
            expectRes(RW'(41 + 2 * i), i == 0, i == 2);
        end
        waitDrain("t3");
        checkOutput("t3_s1_accepts", 32'(acc1Cnt - a1b), 32'd6);
        checkOutput("t3_s0_accepts", 32'(acc0Cnt - a0b), 32'd3);
        checkOutput("t3_err_sync", 32'(err_sync), 32'd0);

        $display("[TB] statistics counters");
        pulseReset();
        pushBeat(0, 10'd88, 1'b0, 1'b0);
        pushBeat(0, 10'd89, 1'b0, 1'b0);
        for (int f = 0; f < 3; f++) begin
            for (int j = 0; j < 2; j++) begin
                pushBeat(0, DW'(10 * f), j == 0, j == 1);
                pushBeat(1, DW'(j + 1), j == 0, j == 1);
                expectRes(RW'(10 * f + j + 1), j == 0, j == 1);
            end
        end
        waitDrain("t5");
`ifdef HDR_STREAM_CTRL_STAT_EN
        checkOutput("t5_frame_cnt", 32'(frame_cnt), 32'd3);
        checkOutput("t5_drop_cnt", 32'(drop_cnt), 32'd2);
`else
        checkOutput("t5_frame_cnt", 32'(frame_cnt), 32'd0);
        checkOutput("t5_drop_cnt", 32'(drop_cnt), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hdr_stream_ctrl.md
HDR_STREAM_CTRL -- requirements
Module: hdr_stream_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10: pixel width of each exposure stream and of the result.
REQ-002 SHALL have parameter HDR_LAT, default 8: fixed cycle latency of the HDR datapath from operand issue to result.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16: result skid FIFO entries, power of two, at least HDR_LAT+2.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-006 SHALL have ports s0_valid/s0_ready/s0_sof/s0_eol (1 each) and s0_data (DATA_WIDTH): short-exposure stream.
REQ-007 SHALL have ports s1_valid/s1_ready/s1_sof/s1_eol (1 each) and s1_data (DATA_WIDTH): long-exposure stream.
REQ-008 SHALL have outputs hdr_data0/hdr_data1 (DATA_WIDTH each): operands to the datapath.
REQ-009 SHALL have input hdr_result (DATA_WIDTH+2): datapath output, sampled HDR_LAT cycles after issue.
REQ-010 SHALL have outputs m_valid/m_sof/m_eol (1 each) and m_data (DATA_WIDTH+2), and input m_ready (1): result stream.
REQ-011 SHALL have output err_sync (1): sticky flag for stream misalignment; cleared only by rst.

Function
REQ-012 Issue occurs in a cycle when the FSM is RUN, s0_valid=1, s1_valid=1 and credit is available.
REQ-013 On issue: s0_ready=s1_ready=1, the operands are registered onto hdr_data0/1, and a valid/sof/eol token enters an HDR_LAT-deep shift pipeline.
REQ-014 Credit is available when in-flight tokens plus FIFO occupancy is less than FIFO_DEPTH; the FIFO therefore never overflows.
REQ-015 When a token exits the shift pipeline, hdr_result and the token's sof/eol are written to the FIFO in that same cycle.
REQ-016 m_valid is FIFO not-empty; an entry is popped when m_valid and m_ready are both 1; data order is preserved.
REQ-017 FIFO write and pop in the same cycle leave occupancy unchanged, including when the FIFO is full or empty.
REQ-018 FSM states: IDLE, RUN, RESYNC.
REQ-019 IDLE: discards any head beat with sof=0 (ready=1 on that stream only); moves to RUN when both heads are valid with sof=1.
REQ-020 RUN: on issue, if s0_sof differs from s1_sof or s0_eol differs from s1_eol, drop the pair (no token), set err_sync, go to RESYNC.
REQ-021 RESYNC: behaves as IDLE (discard non-sof beats, wait for both sof heads), then returns to RUN.
REQ-022 Pipeline tokens and FIFO contents are never flushed by FSM transitions, so results already issued are always delivered.
REQ-023 hdr_data0/1 hold their last value when nothing is issued.
REQ-024 Latency from issue to m_valid is HDR_LAT+1 cycles when the FIFO is empty.

Reset
REQ-025 rst asserted, including mid-frame, SHALL immediately: set FSM to IDLE; clear the shift pipeline, FIFO pointers, credit count and err_sync; drive s0_ready, s1_ready, m_valid, m_sof and m_eol to 0; drive hdr_data0/1 and m_data to 0.
REQ-026 After rst deasserts, the first accepted beats are the next sof on both streams.

Configuration
REQ-027 Macro HDR_STREAM_CTRL_STAT_EN SHALL control the statistics outputs.
REQ-028 With the macro defined, the block adds outputs frame_cnt[15:0] and drop_cnt[15:0]:
- frame_cnt increments on each popped beat with m_eol=1 and m_sof-frame end; it wraps at 0xFFFF to 0.
- drop_cnt increments per discarded beat on either stream and saturates at 0xFFFF.
REQ-029 Without the macro, frame_cnt and drop_cnt are present but tied to 0, and no counter logic is inferred.

Verification
REQ-030 Aligned streams, m_ready=1, 4-pixel line, data0=100, data1=200, hdr_result model=data0+data1: m_data=300 on 4 beats, first beat HDR_LAT+1 cycles after first issue, m_sof on beat 1, m_eol on beat 4.
REQ-031 m_ready=0 for 40 cycles, sources always valid: exactly FIFO_DEPTH issues, no overflow, all 16 results then emerge in order.
REQ-032 s1 has 3 extra non-sof beats before its sof: the 3 beats are dropped; err_sync stays 0; pairing starts at both sof.
REQ-033 eol mismatch mid-line (s0_eol=1, s1_eol=0): the pair is dropped, err_sync=1, FSM goes to RESYNC, and already-issued results are still delivered.
REQ-034 rst pulse while 5 tokens are in flight: m_valid=0 next cycle, no stale results afterward, err_sync=0.
REQ-035 With HDR_STREAM_CTRL_STAT_EN, 3 frames plus 2 dropped beats: frame_cnt=3 and drop_cnt=2; without the macro, both read 0.
